// File: rtl/cpu_mem_responder_pkg.sv
// cpu_mem_responder_pkg
// Shared constants for the CPU memory responder: the position of the opcode
// field inside an instruction word, the opcode values the responder knows
// about, and the run-control FSM state encoding.
package cpu_mem_responder_pkg;

  // Opcode field of a 16-bit instruction word.
  localparam int unsigned OpMsb = 15;
  localparam int unsigned OpLsb = 11;

  // Opcode map of the CPU. Only OpHalt is decoded by the responder.
  localparam logic [4:0] OpNop   = 5'h00;
  localparam logic [4:0] OpAdd   = 5'h01;
  localparam logic [4:0] OpSub   = 5'h02;
  localparam logic [4:0] OpLoad  = 5'h03;
  localparam logic [4:0] OpStore = 5'h04;
  localparam logic [4:0] OpBranch = 5'h05;
  localparam logic [4:0] OpHalt  = 5'h1F;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StStart = 2'b01,
    StRun   = 2'b10,
    StDone  = 2'b11
  } state_e;

endpackage

// File: rtl/cpu_mem_responder_mem_bank.sv
// mem_bank
// Plain 2^ADDR_W x DATA_W storage: one synchronous write port and one
// asynchronous read port. Contents are not reset.
//   clock  : write clock, rising edge
//   we     : write strobe
//   waddr  : write address
//   wdata  : write data
//   raddr  : read address
//   rdata  : read data, combinational from raddr
module mem_bank #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clock) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // A read of the address being written returns the old word this cycle.
  assign rdata = mem_q[raddr];

endmodule

// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder
// Memory-side responder for the pipelined CPU. Holds instruction and data
// memories, serves the CPU fetch and data buses, accepts a host program load,
// and runs the CPU until it fetches HALT or exceeds a cycle limit.
//   clock, reset                  : clock and synchronous active-high reset
//   load_valid/ready/sel/addr/
//   load_data/last                : host load port (sel 0 = imem, 1 = dmem)
//   i_addr -> i_datain            : CPU instruction fetch, combinational
//   d_addr/d_we/d_dataout ->
//   d_datain                      : CPU data access, combinational read
//   cpu_start, cpu_enable         : CPU start pulse and clock enable
//   halted, timeout, cycle_count  : run status, held after a run ends
module cpu_mem_responder
  import cpu_mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DATA_W     = 16,
  parameter logic [15:0] MAX_CYCLES = 16'hFFFF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic              load_sel,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_datain,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_dataout,
  input  logic              d_we,
  output logic [DATA_W-1:0] d_datain,
  output logic              cpu_start,
  output logic              cpu_enable,
  output logic              halted,
  output logic              timeout,
  output logic [15:0]       cycle_count
);

  localparam logic [15:0] LastCycle = MAX_CYCLES - 16'd1;

  state_e      state_q, state_d;
  logic [15:0] count_q, count_d;
  logic        halted_q, halted_d;
  logic        timeout_q, timeout_d;

  logic              imem_we;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_waddr;
  logic [DATA_W-1:0] dmem_wdata;

  mem_bank #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_imem (
    .clock (clock),
    .we    (imem_we),
    .waddr (load_addr),
    .wdata (load_data),
    .raddr (i_addr),
    .rdata (i_datain)
  );

  mem_bank #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_dmem (
    .clock (clock),
    .we    (dmem_we),
    .waddr (dmem_waddr),
    .wdata (dmem_wdata),
    .raddr (d_addr),
    .rdata (d_datain)
  );

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    halted_d   = halted_q;
    timeout_d  = timeout_q;
    load_ready = 1'b0;
    cpu_start  = 1'b0;
    cpu_enable = 1'b0;
    imem_we    = 1'b0;
    dmem_we    = 1'b0;
    // dmem write port belongs to the loader unless the CPU is running.
    dmem_waddr = load_addr;
    dmem_wdata = load_data;

    unique case (state_q)
      StIdle: begin
        load_ready = 1'b1;
        if (load_valid) begin
          imem_we = ~load_sel;
          dmem_we = load_sel;
          if (load_last) begin
            state_d = StStart;
          end
        end
      end
      StStart: begin
        cpu_start  = 1'b1;
        cpu_enable = 1'b1;
        count_d    = 16'd0;
        halted_d   = 1'b0;
        timeout_d  = 1'b0;
        state_d    = StRun;
      end
      StRun: begin
        cpu_enable = 1'b1;
        count_d    = count_q + 16'd1;
        dmem_we    = d_we;
        dmem_waddr = d_addr;
        dmem_wdata = d_dataout;
        // HALT wins over the cycle limit when both hit in the same cycle.
        if (i_datain[OpMsb:OpLsb] == OpHalt) begin
          halted_d = 1'b1;
          state_d  = StDone;
        end else if (count_q == LastCycle) begin
          timeout_d = 1'b1;
          state_d   = StDone;
        end
      end
      StDone: begin
        // The beat that wakes us is dropped; the host presents it again.
        if (load_valid) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Nothing leaves the block and no memory changes while reset is held.
    if (reset) begin
      load_ready = 1'b0;
      cpu_start  = 1'b0;
      cpu_enable = 1'b0;
      imem_we    = 1'b0;
      dmem_we    = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      count_q   <= 16'd0;
      halted_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      halted_q  <= halted_d;
      timeout_q <= timeout_d;
    end
  end

  assign halted      = halted_q;
  assign timeout     = timeout_q;
  assign cycle_count = count_q;

endmodule
